hazard_control: RTL and testbench
=================================

HAZARD_CONTROL -- requirements
Module: hazard_control

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the consecutive data-memory not-ready cycles that trigger ERROR; legal range 1..65535.
REQ-002 Parameter CNT_W, default 16, SHALL set the width of each statistics counter.
REQ-003 CLK  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 RESET  in  1  SHALL be the synchronous, active-high reset.
REQ-005 PCSRC  in  1  SHALL indicate a taken branch resolved in EX (branch_control output).
REQ-006 ID_RS1, ID_RS2  in  5 each  SHALL carry the source register indices of the ID-stage instruction.
REQ-007 EX_RD  in  5, EX_MEMREAD  in  1  SHALL carry the destination index and load flag of the EX-stage instruction.
REQ-008 MEM_REQ  in  1, MEM_READY  in  1  SHALL carry the MEM-stage access request and the data memory ready.
REQ-009 PC_WRITE, IF_ID_WRITE, ID_EX_WRITE, EX_MEM_WRITE  out  1 each  SHALL enable the PC and pipeline registers.
REQ-010 IF_ID_FLUSH, ID_EX_FLUSH  out  1 each  SHALL load a NOP into that register at the edge (valid only with its WRITE=1).
REQ-011 PC_SEL  out  1  SHALL select the branch target (1) or PC+4 (0).
REQ-012 MEM_ERR  out  1  SHALL flag the sticky memory-timeout error; STATE  out  2  SHALL expose RUN=00, MEMWAIT=01, ERROR=10.
REQ-013 BRANCH_CNT, STALL_CNT, WAIT_CNT  out  CNT_W each  SHALL count taken branches, load-use bubbles, memory-wait cycles.

Function
REQ-014 Outputs other than counters/MEM_ERR/STATE SHALL be combinational from state and current inputs (same-cycle hazard response).
REQ-015 Default action (no event): all four WRITE=1, both FLUSH=0, PC_SEL=0.
REQ-016 Memory wait: MEM_REQ=1 and MEM_READY=0 in RUN or MEMWAIT SHALL drive all WRITE=0, FLUSH=0, PC_SEL=0; highest priority.
REQ-017 Branch: PCSRC=1 with no memory wait SHALL drive PC_SEL=1, all WRITE=1, IF_ID_FLUSH=1, ID_EX_FLUSH=1.
REQ-018 Load-use: EX_MEMREAD=1, EX_RD!=0, EX_RD equal to ID_RS1 or ID_RS2, no memory wait, PCSRC=0 SHALL drive PC_WRITE=0, IF_ID_WRITE=0, ID_EX_WRITE=1, ID_EX_FLUSH=1, EX_MEM_WRITE=1.
REQ-019 Load-use with PCSRC=1 SHALL resolve as branch only; STALL_CNT unchanged.
REQ-020 RUN -> MEMWAIT on a memory-wait cycle; MEMWAIT -> RUN at the edge ending a cycle with MEM_READY=1 (or MEM_REQ=0).
REQ-021 The MEMWAIT release cycle SHALL apply REQ-015/017/018 to current inputs (frozen PCSRC is acted on then).
REQ-022 Consecutive not-ready cycles SHALL be counted including the RUN entry cycle; at the edge ending the TIMEOUT-th such cycle, next state SHALL be ERROR.
REQ-023 ERROR SHALL drive all WRITE=0, FLUSH=0, PC_SEL=0, MEM_ERR=1, and persist until RESET regardless of inputs.
REQ-024 BRANCH_CNT +1 per branch cycle (REQ-017), STALL_CNT +1 per load-use cycle (REQ-018), WAIT_CNT +1 per memory-wait cycle (REQ-016); all saturate at 2^CNT_W-1.
REQ-025 Internal timeout counter SHALL clear on any non-wait cycle; WAIT_CNT SHALL not clear.

Reset
REQ-026 RESET=1 at an edge SHALL set STATE=RUN, MEM_ERR=0, all counters and timeout counter 0, overriding any operation including ERROR and MEMWAIT.
REQ-027 While RESET=1, all WRITE=0, FLUSH=0, PC_SEL=0; normal REQ-015 behaviour from the first cycle with RESET=0.

Verification
REQ-028 PCSRC=1 one cycle, MEM_REQ=0 -> PC_SEL=1, IF_ID_FLUSH=ID_EX_FLUSH=1, all WRITE=1; BRANCH_CNT 0->1.
REQ-029 EX_MEMREAD=1, EX_RD=5, ID_RS2=5, PCSRC=0 -> PC_WRITE=IF_ID_WRITE=0, ID_EX_FLUSH=1; STALL_CNT=1; same with EX_RD=0 -> no stall.
REQ-030 Load-use (EX_RD=7=ID_RS1) with PCSRC=1 -> branch outputs only, BRANCH_CNT=1, STALL_CNT=0.
REQ-031 MEM_REQ=1, MEM_READY=0 for 3 cycles then 1 with PCSRC=1 held -> 3 frozen cycles, STATE=01, WAIT_CNT=3, release cycle PC_SEL=1 and flushes, STATE=00 next.
REQ-032 TIMEOUT=4, MEM_READY held 0 -> STATE=10, MEM_ERR=1 after 4th not-ready edge; READY=1 keeps ERROR; RESET -> STATE=00, MEM_ERR=0, counters 0.
REQ-033 CNT_W=4, 20 branch cycles -> BRANCH_CNT saturates at 15.

Source files
------------

// File: rtl/hazard_control_if.sv
// rtl/hazard_control_if.sv - hazard unit pipeline-control bundle
interface hazard_control_if #(
  parameter int unsigned CNT_W = 16
);
  logic             PCSRC;
  logic [4:0]       ID_RS1;
  logic [4:0]       ID_RS2;
  logic [4:0]       EX_RD;
  logic             EX_MEMREAD;
  logic             MEM_REQ;
  logic             MEM_READY;
  logic             PC_WRITE;
  logic             IF_ID_WRITE;
  logic             ID_EX_WRITE;
  logic             EX_MEM_WRITE;
  logic             IF_ID_FLUSH;
  logic             ID_EX_FLUSH;
  logic             PC_SEL;
  logic             MEM_ERR;
  logic [1:0]       STATE;
  logic [CNT_W-1:0] BRANCH_CNT;
  logic [CNT_W-1:0] STALL_CNT;
  logic [CNT_W-1:0] WAIT_CNT;

  // pipeline side: supplies hazard inputs, consumes enables
  modport master (
    output PCSRC, ID_RS1, ID_RS2, EX_RD, EX_MEMREAD, MEM_REQ, MEM_READY,
    input  PC_WRITE, IF_ID_WRITE, ID_EX_WRITE, EX_MEM_WRITE,
    input  IF_ID_FLUSH, ID_EX_FLUSH, PC_SEL, MEM_ERR, STATE,
    input  BRANCH_CNT, STALL_CNT, WAIT_CNT
  );

  // hazard unit side
  modport slave (
    input  PCSRC, ID_RS1, ID_RS2, EX_RD, EX_MEMREAD, MEM_REQ, MEM_READY,
    output PC_WRITE, IF_ID_WRITE, ID_EX_WRITE, EX_MEM_WRITE,
    output IF_ID_FLUSH, ID_EX_FLUSH, PC_SEL, MEM_ERR, STATE,
    output BRANCH_CNT, STALL_CNT, WAIT_CNT
  );
endinterface

// File: rtl/hazard_control.sv
// rtl/hazard_control.sv - pipeline hazard, branch flush and memory-wait control
module hazard_control #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input logic             CLK,
  input logic             RESET,
  hazard_control_if.slave bus
);
  typedef enum logic [1:0] {
    RUN     = 2'b00,
    MEMWAIT = 2'b01,
    ERROR   = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  // the timeout counter holds completed not-ready cycles, so the
  // TIMEOUT-th one is seen while it still reads TIMEOUT-1
  localparam logic [15:0]      TO_LAST = 16'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic             mem_err_q, mem_err_d;
  logic [15:0]      to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic active;
  logic mem_wait;
  logic branch;
  logic load_use;
  logic rd_match;

  // event decode in priority order: memory wait, branch, load-use
  always_comb begin
    active   = !RESET && (state_q != ERROR);
    mem_wait = active && bus.MEM_REQ && !bus.MEM_READY;
    rd_match = (bus.EX_RD != 5'd0) &&
               ((bus.EX_RD == bus.ID_RS1) || (bus.EX_RD == bus.ID_RS2));
    branch   = active && !mem_wait && bus.PCSRC;
    load_use = active && !mem_wait && !bus.PCSRC && bus.EX_MEMREAD && rd_match;
  end

  // same-cycle pipeline enables; everything frozen in reset, error or wait
  always_comb begin
    bus.PC_WRITE     = 1'b0;
    bus.IF_ID_WRITE  = 1'b0;
    bus.ID_EX_WRITE  = 1'b0;
    bus.EX_MEM_WRITE = 1'b0;
    bus.IF_ID_FLUSH  = 1'b0;
    bus.ID_EX_FLUSH  = 1'b0;
    bus.PC_SEL       = 1'b0;
    if (active && !mem_wait) begin
      bus.PC_WRITE     = 1'b1;
      bus.IF_ID_WRITE  = 1'b1;
      bus.ID_EX_WRITE  = 1'b1;
      bus.EX_MEM_WRITE = 1'b1;
      if (branch) begin
        bus.PC_SEL      = 1'b1;
        bus.IF_ID_FLUSH = 1'b1;
        bus.ID_EX_FLUSH = 1'b1;
      end else if (load_use) begin
        bus.PC_WRITE    = 1'b0;
        bus.IF_ID_WRITE = 1'b0;
        bus.ID_EX_FLUSH = 1'b1;
      end
    end
  end

  // next state, timeout tracking and saturating statistics
  always_comb begin
    state_d      = state_q;
    mem_err_d    = mem_err_q;
    to_cnt_d     = to_cnt_q;
    branch_cnt_d = branch_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    if (state_q != ERROR) begin
      if (mem_wait) begin
        if (to_cnt_q == TO_LAST) begin
          state_d   = ERROR;
          mem_err_d = 1'b1;
          to_cnt_d  = '0;
        end else begin
          state_d  = MEMWAIT;
          to_cnt_d = to_cnt_q + 16'd1;
        end
      end else begin
        state_d  = RUN;
        to_cnt_d = '0;
      end
    end
    if (branch && (branch_cnt_q != CNT_MAX)) branch_cnt_d = branch_cnt_q + 1'b1;
    if (load_use && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (mem_wait && (wait_cnt_q != CNT_MAX)) wait_cnt_d = wait_cnt_q + 1'b1;
  end

  // state registers; reset overrides every state including ERROR
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= RUN;
      mem_err_q    <= 1'b0;
      to_cnt_q     <= '0;
      branch_cnt_q <= '0;
      stall_cnt_q  <= '0;
      wait_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      mem_err_q    <= mem_err_d;
      to_cnt_q     <= to_cnt_d;
      branch_cnt_q <= branch_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  assign bus.STATE      = state_q;
  assign bus.MEM_ERR    = mem_err_q;
  assign bus.BRANCH_CNT = branch_cnt_q;
  assign bus.STALL_CNT  = stall_cnt_q;
  assign bus.WAIT_CNT   = wait_cnt_q;
endmodule

// File: tb/tb_hazard_control.sv
// tb/tb_hazard_control.sv - self-checking bench for hazard_control
module tb_hazard_control;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  int   checks = 0;
  int   failures = 0;

  localparam logic [6:0] C_NORMAL = 7'b1111_000;
  localparam logic [6:0] C_BRANCH = 7'b1111_111;
  localparam logic [6:0] C_STALL  = 7'b0011_010;
  localparam logic [6:0] C_FROZEN = 7'b0000_000;

  hazard_control_if #(.CNT_W(4))  ia ();
  hazard_control_if #(.CNT_W(16)) ib ();

  hazard_control #(.TIMEOUT(4), .CNT_W(4)) dut_a (
    .CLK(CLK), .RESET(RESET), .bus(ia.slave)
  );
  hazard_control #(.TIMEOUT(255), .CNT_W(16)) dut_b (
    .CLK(CLK), .RESET(RESET), .bus(ib.slave)
  );

  always #5 CLK = ~CLK;

  // control vector order: PC_WRITE IF_ID_WRITE ID_EX_WRITE EX_MEM_WRITE IF_ID_FLUSH ID_EX_FLUSH PC_SEL
  logic [6:0] ctl_a, ctl_b;
  assign ctl_a = {ia.PC_WRITE, ia.IF_ID_WRITE, ia.ID_EX_WRITE, ia.EX_MEM_WRITE,
                  ia.IF_ID_FLUSH, ia.ID_EX_FLUSH, ia.PC_SEL};
  assign ctl_b = {ib.PC_WRITE, ib.IF_ID_WRITE, ib.ID_EX_WRITE, ib.EX_MEM_WRITE,
                  ib.IF_ID_FLUSH, ib.ID_EX_FLUSH, ib.PC_SEL};

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic pcsrc, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic memread, input logic req,
                       input logic ready);
    ia.PCSRC = pcsrc; ia.ID_RS1 = rs1; ia.ID_RS2 = rs2; ia.EX_RD = rd;
    ia.EX_MEMREAD = memread; ia.MEM_REQ = req; ia.MEM_READY = ready;
    ib.PCSRC = pcsrc; ib.ID_RS1 = rs1; ib.ID_RS2 = rs2; ib.EX_RD = rd;
    ib.EX_MEMREAD = memread; ib.MEM_REQ = req; ib.MEM_READY = ready;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    tick();
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    drive(1'b1, 5'd1, 5'd1, 5'd1, 1'b1, 1'b0, 1'b1);
    #2;
    checks++; if (ctl_a !== C_FROZEN) begin failures++; $display("FAIL reset_ctl_a got=%b exp=%b", ctl_a, C_FROZEN); end
    checks++; if (ctl_b !== C_FROZEN) begin failures++; $display("FAIL reset_ctl_b got=%b exp=%b", ctl_b, C_FROZEN); end
    tick();
    checks++; if (ia.STATE !== 2'b00) begin failures++; $display("FAIL reset_state got=%b exp=00", ia.STATE); end
    checks++; if (ia.MEM_ERR !== 1'b0) begin failures++; $display("FAIL reset_mem_err got=%b exp=0", ia.MEM_ERR); end
    checks++; if ({ib.BRANCH_CNT, ib.STALL_CNT, ib.WAIT_CNT} !== 48'd0) begin failures++; $display("FAIL reset_counters got=%h exp=0", {ib.BRANCH_CNT, ib.STALL_CNT, ib.WAIT_CNT}); end
    RESET = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    #2;
    checks++; if (ctl_b !== C_NORMAL) begin failures++; $display("FAIL first_run_ctl got=%b exp=%b", ctl_b, C_NORMAL); end
  endtask

  task automatic test_branch();
    do_reset();
    drive(1'b1, 5'd2, 5'd3, 5'd4, 1'b0, 1'b0, 1'b0);
    #2;
    checks++; if (ctl_b !== C_BRANCH) begin failures++; $display("FAIL branch_ctl got=%b exp=%b", ctl_b, C_BRANCH); end
    tick();
    checks++; if (ib.BRANCH_CNT !== 16'd1) begin failures++; $display("FAIL branch_cnt got=%0d exp=1", ib.BRANCH_CNT); end
    drive(1'b0, 5'd2, 5'd3, 5'd4, 1'b0, 1'b0, 1'b0);
    #2;
    checks++; if (ctl_b !== C_NORMAL) begin failures++; $display("FAIL branch_after_ctl got=%b exp=%b", ctl_b, C_NORMAL); end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1'b0, 5'd3, 5'd5, 5'd5, 1'b1, 1'b0, 1'b1);
    #2;
    checks++; if (ctl_b !== C_STALL) begin failures++; $display("FAIL load_use_ctl got=%b exp=%b", ctl_b, C_STALL); end
    tick();
    checks++; if (ib.STALL_CNT !== 16'd1) begin failures++; $display("FAIL load_use_cnt got=%0d exp=1", ib.STALL_CNT); end
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1);
    #2;
    checks++; if (ctl_b !== C_NORMAL) begin failures++; $display("FAIL rd_zero_ctl got=%b exp=%b", ctl_b, C_NORMAL); end
    tick();
    checks++; if (ib.STALL_CNT !== 16'd1) begin failures++; $display("FAIL rd_zero_cnt got=%0d exp=1", ib.STALL_CNT); end
  endtask

  task automatic test_load_use_branch();
    do_reset();
    drive(1'b1, 5'd7, 5'd1, 5'd7, 1'b1, 1'b0, 1'b1);
    #2;
    checks++; if (ctl_b !== C_BRANCH) begin failures++; $display("FAIL lu_branch_ctl got=%b exp=%b", ctl_b, C_BRANCH); end
    tick();
    checks++; if (ib.BRANCH_CNT !== 16'd1) begin failures++; $display("FAIL lu_branch_bcnt got=%0d exp=1", ib.BRANCH_CNT); end
    checks++; if (ib.STALL_CNT !== 16'd0) begin failures++; $display("FAIL lu_branch_scnt got=%0d exp=0", ib.STALL_CNT); end
  endtask

  task automatic test_memwait();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      #2;
      checks++; if (ctl_b !== C_FROZEN) begin failures++; $display("FAIL memwait_ctl[%0d] got=%b exp=%b", i, ctl_b, C_FROZEN); end
      tick();
      checks++; if (ib.STATE !== 2'b01) begin failures++; $display("FAIL memwait_state[%0d] got=%b exp=01", i, ib.STATE); end
    end
    checks++; if (ib.WAIT_CNT !== 16'd3) begin failures++; $display("FAIL memwait_cnt got=%0d exp=3", ib.WAIT_CNT); end
    checks++; if (ia.STATE !== 2'b01) begin failures++; $display("FAIL memwait_short_to got=%b exp=01", ia.STATE); end
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    #2;
    checks++; if (ctl_b !== C_BRANCH) begin failures++; $display("FAIL release_ctl got=%b exp=%b", ctl_b, C_BRANCH); end
    tick();
    checks++; if (ib.STATE !== 2'b00) begin failures++; $display("FAIL release_state got=%b exp=00", ib.STATE); end
    checks++; if (ib.BRANCH_CNT !== 16'd1) begin failures++; $display("FAIL release_bcnt got=%0d exp=1", ib.BRANCH_CNT); end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      tick();
      checks++; if (ia.STATE !== ((i == 4) ? 2'b10 : 2'b01)) begin failures++; $display("FAIL timeout_state[%0d] got=%b exp=%b", i, ia.STATE, (i == 4) ? 2'b10 : 2'b01); end
    end
    checks++; if (ia.MEM_ERR !== 1'b1) begin failures++; $display("FAIL timeout_mem_err got=%b exp=1", ia.MEM_ERR); end
    checks++; if (ib.STATE !== 2'b01) begin failures++; $display("FAIL long_to_state got=%b exp=01", ib.STATE); end
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    #2;
    checks++; if (ctl_a !== C_FROZEN) begin failures++; $display("FAIL error_ctl got=%b exp=%b", ctl_a, C_FROZEN); end
    tick();
    checks++; if (ia.STATE !== 2'b10) begin failures++; $display("FAIL error_sticky got=%b exp=10", ia.STATE); end
    checks++; if (ia.BRANCH_CNT !== 4'd0) begin failures++; $display("FAIL error_bcnt got=%0d exp=0", ia.BRANCH_CNT); end
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    checks++; if (ia.STATE !== 2'b00) begin failures++; $display("FAIL error_reset_state got=%b exp=00", ia.STATE); end
    checks++; if (ia.MEM_ERR !== 1'b0) begin failures++; $display("FAIL error_reset_err got=%b exp=0", ia.MEM_ERR); end
    checks++; if (ia.WAIT_CNT !== 4'd0) begin failures++; $display("FAIL error_reset_wcnt got=%0d exp=0", ia.WAIT_CNT); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      tick();
    end
    checks++; if (ia.BRANCH_CNT !== 4'd15) begin failures++; $display("FAIL sat_bcnt_w4 got=%0d exp=15", ia.BRANCH_CNT); end
    checks++; if (ib.BRANCH_CNT !== 16'd20) begin failures++; $display("FAIL sat_bcnt_w16 got=%0d exp=20", ib.BRANCH_CNT); end
  endtask

  // reference: per-instance abstract bookkeeping of the spec's rules
  task automatic test_random();
    int  lim[2]  = '{4, 255};
    int  cmax[2] = '{15, 65535};
    int  m_b[2], m_s[2], m_w[2], m_run[2];
    bit  m_err[2], m_wt[2];
    logic [6:0] exp_ctl[2];
    logic [6:0] got_ctl;
    int  got_st, got_err, got_b, got_s, got_w, exp_st;
    logic pc, mr, rq, rdy, rst;
    logic [4:0] r1, r2, rd;
    bit waitc, lu;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      m_b[k] = 0; m_s[k] = 0; m_w[k] = 0; m_run[k] = 0; m_err[k] = 0; m_wt[k] = 0;
    end
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      pc  = ($urandom_range(0, 3) == 0);
      r1  = 5'($urandom_range(0, 3));
      r2  = 5'($urandom_range(0, 3));
      rd  = 5'($urandom_range(0, 3));
      mr  = 1'($urandom_range(0, 1));
      rq  = 1'($urandom_range(0, 1));
      rdy = ($urandom_range(0, 9) < 6);
      RESET = rst;
      drive(pc, r1, r2, rd, mr, rq, rdy);
      waitc = rq && !rdy;
      lu = mr && (rd != 0) && (rd == r1 || rd == r2);
      #2;
      for (int k = 0; k < 2; k++) begin
        if (rst || m_err[k] || waitc) exp_ctl[k] = C_FROZEN;
        else if (pc) exp_ctl[k] = C_BRANCH;
        else if (lu) exp_ctl[k] = C_STALL;
        else exp_ctl[k] = C_NORMAL;
        got_ctl = (k == 0) ? ctl_a : ctl_b;
        checks++; if (got_ctl !== exp_ctl[k]) begin failures++; $display("FAIL rnd_ctl[%0d] n=%0d got=%b exp=%b", k, n, got_ctl, exp_ctl[k]); end
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        if (rst) begin
          m_b[k] = 0; m_s[k] = 0; m_w[k] = 0; m_run[k] = 0; m_err[k] = 0; m_wt[k] = 0;
        end else if (!m_err[k]) begin
          if (waitc) begin
            m_w[k] = (m_w[k] < cmax[k]) ? m_w[k] + 1 : m_w[k];
            m_run[k]++;
            m_wt[k] = 1;
            if (m_run[k] >= lim[k]) m_err[k] = 1;
          end else begin
            m_run[k] = 0;
            m_wt[k] = 0;
            if (pc) m_b[k] = (m_b[k] < cmax[k]) ? m_b[k] + 1 : m_b[k];
            else if (lu) m_s[k] = (m_s[k] < cmax[k]) ? m_s[k] + 1 : m_s[k];
          end
        end
        exp_st  = m_err[k] ? 2 : (m_wt[k] ? 1 : 0);
        got_st  = (k == 0) ? int'(ia.STATE) : int'(ib.STATE);
        got_err = (k == 0) ? int'(ia.MEM_ERR) : int'(ib.MEM_ERR);
        got_b   = (k == 0) ? int'(ia.BRANCH_CNT) : int'(ib.BRANCH_CNT);
        got_s   = (k == 0) ? int'(ia.STALL_CNT) : int'(ib.STALL_CNT);
        got_w   = (k == 0) ? int'(ia.WAIT_CNT) : int'(ib.WAIT_CNT);
        checks++; if (got_st !== exp_st) begin failures++; $display("FAIL rnd_state[%0d] n=%0d got=%0d exp=%0d", k, n, got_st, exp_st); end
        checks++; if (got_err !== int'(m_err[k])) begin failures++; $display("FAIL rnd_err[%0d] n=%0d got=%0d exp=%0d", k, n, got_err, m_err[k]); end
        checks++; if (got_b !== m_b[k]) begin failures++; $display("FAIL rnd_bcnt[%0d] n=%0d got=%0d exp=%0d", k, n, got_b, m_b[k]); end
        checks++; if (got_s !== m_s[k]) begin failures++; $display("FAIL rnd_scnt[%0d] n=%0d got=%0d exp=%0d", k, n, got_s, m_s[k]); end
        checks++; if (got_w !== m_w[k]) begin failures++; $display("FAIL rnd_wcnt[%0d] n=%0d got=%0d exp=%0d", k, n, got_w, m_w[k]); end
      end
    end
    RESET = 1'b0;
  endtask

  initial begin
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    test_reset();
    test_branch();
    test_load_use();
    test_load_use_branch();
    test_memwait();
    test_timeout();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
